// File: rtl/key_led_pkg.sv
// key_led_pkg: shared types and helpers for the key-to-LED counter.
// Debounce state encoding, key indices and counter width sizing.
package key_led_pkg;

  typedef enum logic [1:0] {
    IDLE,
    F_DOWN,
    DOWN,
    F_UP
  } db_state_t;

  localparam int KEY_INC = 0;
  localparam int KEY_DEC = 1;
  localparam int KEY_CLR = 2;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_rpt.sv
// key_debounce_rpt: sync, debounce and auto-repeat for one active-low key.
// Emits a debounced level and a one-cycle pulse per press or repeat.
module key_debounce_rpt
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int RPT_EN       = 1,
  parameter int REPEAT_DLY   = 25_000_000,
  parameter int REPEAT_PER   = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_state,
  output logic key_evt
);

  localparam int FW = cnt_w(DEBOUNCE_CYC);
  localparam int RMAX =
    (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW = cnt_w(RMAX);

  // fcnt tracks stable samples after the first one,
  // so the filter closes at DEBOUNCE_CYC-2.
  localparam logic [FW-1:0] F_LAST = FW'(DEBOUNCE_CYC - 2);
  localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PER - 1);

  logic          s1;
  logic          s2;
  db_state_t     st;
  logic [FW-1:0] fcnt;
  logic [RW-1:0] rcnt;
  logic          rpt_per;
  logic          press_acc;
  logic          rel_acc;
  logic          rpt_run;
  logic          rpt_hit;
  logic [RW-1:0] rpt_lim;

  assign press_acc = (st == F_DOWN) && !s2
                   && (fcnt == F_LAST);
  assign rel_acc   = (st == F_UP) && s2
                   && (fcnt == F_LAST);
  assign rpt_run   = (RPT_EN != 0)
                   && ((st == DOWN)
                   || ((st == F_UP) && !rel_acc));
  assign rpt_lim   = rpt_per ? R_PER : R_DLY;
  assign rpt_hit   = rpt_run && (rcnt == rpt_lim);

  // Two-flop synchroniser, preset to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  // Debounce FSM with registered level and event outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      fcnt      <= '0;
      key_state <= 1'b1;
      key_evt   <= 1'b0;
    end else begin
      key_evt <= press_acc || rpt_hit;
      unique case (st)
        IDLE: begin
          if (!s2) begin
            st   <= F_DOWN;
            fcnt <= '0;
          end
        end
        F_DOWN: begin
          if (s2) begin
            st <= IDLE;
          end else if (press_acc) begin
            st        <= DOWN;
            key_state <= 1'b0;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
        DOWN: begin
          if (s2) begin
            st   <= F_UP;
            fcnt <= '0;
          end
        end
        F_UP: begin
          if (!s2) begin
            st <= DOWN;
          end else if (rel_acc) begin
            st        <= IDLE;
            key_state <= 1'b1;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Repeat timer: restarts on a fresh press only, so a
  // release bounce back into DOWN keeps the cadence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt    <= '0;
      rpt_per <= 1'b0;
    end else if (press_acc) begin
      rcnt    <= '0;
      rpt_per <= 1'b0;
    end else if (rpt_hit) begin
      rcnt    <= '0;
      rpt_per <= 1'b1;
    end else if (rpt_run) begin
      rcnt <= rcnt + RW'(1);
    end
  end

endmodule

// File: rtl/key_led_multi.sv
// key_led_multi: three debounced keys driving an up/down LED counter.
// inc/dec may auto-repeat; clr wins; wrap or saturate at the ends.
module key_led_multi
  import key_led_pkg::*;
#(
  parameter int LED_W        = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DLY   = 25_000_000,
  parameter int REPEAT_PER   = 5_000_000,
  parameter int WRAP         = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       key_in,
  output logic [LED_W-1:0] led,
  output logic [2:0]       key_state,
  output logic [2:0]       key_evt,
  output logic             ovf
);

  localparam logic [LED_W-1:0] LED_MAX = '1;

  logic do_clr;
  logic do_inc;
  logic do_dec;

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce_rpt #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .RPT_EN      ((i == KEY_CLR) ? 0 : REPEAT_EN),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_PER  (REPEAT_PER)
    ) u_key (
      .clk      (clk),
      .rst      (rst),
      .key_n    (key_in[i]),
      .key_state(key_state[i]),
      .key_evt  (key_evt[i])
    );
  end

  // inc+dec together cancel; clr overrides both.
  assign do_clr = key_evt[KEY_CLR];
  assign do_inc = !do_clr && key_evt[KEY_INC]
               && !key_evt[KEY_DEC];
  assign do_dec = !do_clr && key_evt[KEY_DEC]
               && !key_evt[KEY_INC];

  // Counter update with wrap/saturate and ovf pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
      ovf <= 1'b0;
    end else begin
      ovf <= 1'b0;
      unique case (1'b1)
        do_clr: led <= '0;
        do_inc: begin
          if (led == LED_MAX) begin
            ovf <= 1'b1;
            if (WRAP != 0) led <= '0;
          end else begin
            led <= led + LED_W'(1);
          end
        end
        do_dec: begin
          if (led == '0) begin
            ovf <= 1'b1;
            if (WRAP != 0) led <= LED_MAX;
          end else begin
            led <= led - LED_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_led_multi.sv
// tb_key_led_multi: bench for key_led_multi, wrap and saturate builds.
// Stable-run key model plus vector table and corner sequences.
module tb_key_led_multi;

  localparam int LW = 4;
  localparam int DC = 10;
  localparam int RD = 50;
  localparam int RP = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    key_in = 3'b111;
  logic [LW-1:0] led_w;
  logic [LW-1:0] led_s;
  logic [2:0]    ks_w;
  logic [2:0]    ks_s;
  logic [2:0]    ev_w;
  logic [2:0]    ev_s;
  logic          ovf_w;
  logic          ovf_s;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  key_led_multi #(
    .LED_W(LW), .DEBOUNCE_CYC(DC), .REPEAT_EN(1),
    .REPEAT_DLY(RD), .REPEAT_PER(RP), .WRAP(1)
  ) dut_w (
    .clk(clk), .rst(rst), .key_in(key_in),
    .led(led_w), .key_state(ks_w),
    .key_evt(ev_w), .ovf(ovf_w)
  );

  key_led_multi #(
    .LED_W(LW), .DEBOUNCE_CYC(DC), .REPEAT_EN(1),
    .REPEAT_DLY(RD), .REPEAT_PER(RP), .WRAP(0)
  ) dut_s (
    .clk(clk), .rst(rst), .key_in(key_in),
    .led(led_s), .key_state(ks_s),
    .key_evt(ev_s), .ovf(ovf_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input int got,
                     input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Reference: a key level is accepted once the synchronised
  // input has shown the other level for DC consecutive edges.
  // Presses pulse; held inc/dec pulse again at +RD, +RD+k*RP.
  int         m_cyc = 0;
  logic [2:0] h1, h2, m_acc, m_evt, n_evt, run_lvl;
  int         run[3];
  int         pt[3];
  int         m_led_w, m_led_s;
  bit         m_ovf_w, m_ovf_s;
  int         dd;
  logic       ks;

  function automatic int next_led(input int v,
      input logic [2:0] e, input bit wrap, output bit o);
    int mx;
    mx = (1 << LW) - 1;
    o = 1'b0;
    if (e[2]) return 0;
    if (e[0] && e[1]) return v;
    if (e[0]) begin
      if (v == mx) begin
        o = 1'b1;
        return wrap ? 0 : mx;
      end
      return v + 1;
    end
    if (e[1]) begin
      if (v == 0) begin
        o = 1'b1;
        return wrap ? mx : 0;
      end
      return v - 1;
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h1 = '1; h2 = '1; m_acc = '1; m_evt = '0;
      run_lvl = '1;
      m_led_w = 0; m_led_s = 0;
      m_ovf_w = 1'b0; m_ovf_s = 1'b0;
      for (int k = 0; k < 3; k++) begin
        run[k] = 0;
        pt[k] = 0;
      end
    end else begin
      m_cyc++;
      m_led_w = next_led(m_led_w, m_evt, 1'b1, m_ovf_w);
      m_led_s = next_led(m_led_s, m_evt, 1'b0, m_ovf_s);
      n_evt = '0;
      for (int k = 0; k < 3; k++) begin
        ks = h2[k];
        if (ks == run_lvl[k]) run[k]++;
        else begin
          run[k] = 1;
          run_lvl[k] = ks;
        end
        if (ks != m_acc[k] && run[k] == DC) begin
          m_acc[k] = ks;
          if (!ks) begin
            n_evt[k] = 1'b1;
            pt[k] = m_cyc;
          end
        end else if (!m_acc[k] && k != 2) begin
          dd = m_cyc - pt[k];
          if (dd == RD || (dd > RD && (dd - RD) % RP == 0))
            n_evt[k] = 1'b1;
        end
      end
      m_evt = n_evt;
      h2 = h1;
      h1 = key_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("led_w", int'(led_w), m_led_w);
      chk("led_s", int'(led_s), m_led_s);
      chk("kst_w", int'(ks_w), int'(m_acc));
      chk("kst_s", int'(ks_s), int'(m_acc));
      chk("evt_w", int'(ev_w), int'(m_evt));
      chk("evt_s", int'(ev_s), int'(m_evt));
      chk("ovf_w", int'(ovf_w), int'(m_ovf_w));
      chk("ovf_s", int'(ovf_s), int'(m_ovf_s));
    end
  end

  typedef struct {
    logic [2:0] keys;
    int         hold;
    int         exp_w;
    int         exp_s;
  } vec_t;

  vec_t vecs[13];
  int   nev;
  logic [2:0] p;

  initial begin
    // keys: bit0 inc, bit1 dec, bit2 clr (pressed = 1)
    vecs[0]  = '{3'b100,  30,  0, 0};
    vecs[1]  = '{3'b001,  30,  1, 1};
    vecs[2]  = '{3'b001,  30,  2, 2};
    vecs[3]  = '{3'b010,  30,  1, 1};
    vecs[4]  = '{3'b011,  30,  1, 1};
    vecs[5]  = '{3'b101,  30,  0, 0};
    vecs[6]  = '{3'b010,  30, 15, 0};
    vecs[7]  = '{3'b001,  30,  0, 1};
    vecs[8]  = '{3'b001, 100,  4, 5};
    vecs[9]  = '{3'b011, 100,  4, 5};
    vecs[10] = '{3'b010, 100,  0, 1};
    vecs[11] = '{3'b010,  30, 15, 0};
    vecs[12] = '{3'b001,  30,  0, 1};

    repeat (3) @(negedge clk);
    chk("rst_led", int'(led_w), 0);
    chk("rst_kst", int'(ks_w), 7);
    chk("rst_evt", int'(ev_w), 0);
    chk("rst_ovf", int'(ovf_w), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // clean press: event exactly 12 edges after the fall
    key_in = 3'b110;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("lat_evt", int'(ev_w[0]), (i == 12) ? 1 : 0);
    end
    @(negedge clk);
    chk("lat_led", int'(led_w), 1);
    chk("hold_kst", int'(ks_w[0]), 0);
    repeat (17) @(negedge clk);
    key_in = 3'b111;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("rel_kst", int'(ks_w[0]), (i == 12) ? 1 : 0);
    end
    repeat (5) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      key_in = ~vecs[i].keys;
      repeat (vecs[i].hold) @(negedge clk);
      key_in = 3'b111;
      repeat (25) @(negedge clk);
      chk($sformatf("vec%0d_w", i), int'(led_w),
          vecs[i].exp_w);
      chk($sformatf("vec%0d_s", i), int'(led_s),
          vecs[i].exp_s);
    end

    // chatter on inc: low stretches all shorter than DC
    nev = 0;
    for (int b = 0; b < 8; b++) begin
      key_in = 3'b110;
      repeat ($urandom_range(1, DC - 1)) begin
        @(negedge clk);
        if (ev_w[0]) nev++;
      end
      key_in = 3'b111;
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        if (ev_w[0]) nev++;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (ev_w[0]) nev++;
    end
    chk("chat_evt", nev, 0);
    key_in = 3'b110;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("chat_lat", int'(ev_w[0]), (i == 12) ? 1 : 0);
    end
    @(negedge clk);
    chk("chat_led", int'(led_w), 1);
    repeat (17) @(negedge clk);
    key_in = 3'b111;
    repeat (20) @(negedge clk);

    // reset while inc is mid-filter (fcnt=5)
    key_in = 3'b110;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("amid_led", int'(led_w), 0);
    chk("amid_lds", int'(led_s), 0);
    chk("amid_kst", int'(ks_w), 7);
    chk("amid_evt", int'(ev_w), 0);
    chk("amid_ovf", int'(ovf_w), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("post_lat", int'(ev_w[0]), (i == 12) ? 1 : 0);
    end
    key_in = 3'b111;
    repeat (20) @(negedge clk);

    // random key traffic against the model
    for (int r = 0; r < 200; r++) begin
      p = 3'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) p[2] = 1'b1;
      key_in = ~p;
      repeat ($urandom_range(1, 80)) @(negedge clk);
      key_in = 3'b111;
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    key_in = 3'b111;
    repeat (30) @(negedge clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
